score_display_ctrl: RTL and testbench

//   Sequencer feeding the 4-digit seven-segment mux (16-bit nibble-packed "value", nibble 4'hF = blank).

---
 rtl/score_display_ctrl_if.sv | 24 ++
 rtl/score_display_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_score_display_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/score_display_ctrl_if.sv
// Bundle of game counters in and seven-segment mux data out for score_display_ctrl.
interface score_display_ctrl_if #(
    parameter int unsigned IN_W = 14
);
    logic [IN_W-1:0] score;
    logic [IN_W-1:0] lines;
    logic [IN_W-1:0] level;
    logic            hold;
    logic [15:0]     value;
    logic [1:0]      page_sel;
    logic            busy;

    // Game logic / testbench side: supplies counters and hold, observes the display.
    modport master (
        output score, lines, level, hold,
        input  value, page_sel, busy
    );

    // Display controller side.
    modport slave (
        input  score, lines, level, hold,
        output value, page_sel, busy
    );
endinterface

// File: rtl/score_display_ctrl.sv
// Display sequencer for a 4-digit seven-segment mux. Rotates through score/lines/level on a
// page timer, converts the selected counter to BCD with a serial double-dabble engine and
// commits a leading-zero-blanked result atomically.
module score_display_ctrl #(
    parameter int unsigned PAGE_TICKS = 100_000_000,
    parameter int unsigned IN_W       = 14,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    score_display_ctrl_if.slave bus_io
);

    localparam int unsigned TimerW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
    localparam int unsigned CntW   = $clog2(IN_W + 1);
    localparam int unsigned SatMax = 9999;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_e;

    state_e          state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]      page_q, page_d;
    logic            page_adv;

    logic [1:0]      cap_page_q, cap_page_d;
    logic [IN_W-1:0] cap_bin_q, cap_bin_d;
    logic            valid_q, valid_d;
    logic [15:0]     acc_q, acc_d;
    logic [IN_W-1:0] bin_q, bin_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     value_q, value_d;

    logic [IN_W-1:0] src_raw;
    logic [IN_W-1:0] src_sat;
    logic            req;
    logic [15:0]     acc_adj;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] a);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < 4; i++) begin
            if (a[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Replace leading zero digits with blank (4'hF); the rightmost digit always shows.
    function automatic logic [15:0] blank_lz(input logic [15:0] a);
        logic [15:0] r;
        logic        lead;
        r    = a;
        lead = BLANK_LZ;
        for (int i = 3; i >= 1; i--) begin
            if (lead && (a[i*4 +: 4] == 4'd0)) begin
                r[i*4 +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    // Page timer and page rotation; hold freezes both.
    always_comb begin
        page_adv = !bus_io.hold && (timer_q == TimerW'(PAGE_TICKS - 1));
        timer_d  = timer_q;
        page_d   = page_q;
        if (!bus_io.hold) begin
            timer_d = page_adv ? '0 : timer_q + 1'b1;
        end
        if (page_adv) begin
            page_d = (page_q == 2'd2) ? 2'd0 : page_q + 2'd1;
        end
    end

    // Select the shown counter, saturate to four digits and decide whether it needs converting.
    always_comb begin
        case (page_q)
            2'd1:    src_raw = bus_io.lines;
            2'd2:    src_raw = bus_io.level;
            default: src_raw = bus_io.score;
        endcase
        if (32'(src_raw) > SatMax) begin
            src_sat = IN_W'(SatMax);
        end else begin
            src_sat = src_raw;
        end
        req = !valid_q || (page_q != cap_page_q) || (src_sat != cap_bin_q);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req) state_d = StLoad;
            StLoad:   state_d = StShift;
            StShift:  if (cnt_q == CntW'(1)) state_d = StCommit;
            StCommit: state_d = StIdle;
        endcase
    end

    // Conversion datapath next-state, steered by the FSM state.
    always_comb begin
        cap_page_d = cap_page_q;
        cap_bin_d  = cap_bin_q;
        valid_d    = valid_q;
        acc_d      = acc_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        value_d    = value_q;
        acc_adj    = dabble_adjust(acc_q);
        unique case (state_q)
            StIdle: ;
            StLoad: begin
                cap_page_d = page_q;
                cap_bin_d  = src_sat;
                bin_d      = src_sat;
                acc_d      = '0;
                cnt_d      = CntW'(IN_W);
            end
            StShift: begin
                {acc_d, bin_d} = {acc_adj[14:0], bin_q, 1'b0};
                cnt_d          = cnt_q - 1'b1;
            end
            StCommit: begin
                // A page change during (or on the edge ending) the conversion makes the result
                // stale; drop it so the IDLE compare reconverts for the new page.
                if ((cap_page_q == page_q) && !page_adv) begin
                    value_d = blank_lz(acc_q);
                    valid_d = 1'b1;
                end
            end
        endcase
    end

    // Timer, page and datapath registers; reset forces a fresh conversion afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q    <= '0;
            page_q     <= 2'd0;
            cap_page_q <= 2'd0;
            cap_bin_q  <= '0;
            valid_q    <= 1'b0;
            acc_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            value_q    <= 16'hFFFF;
        end else begin
            timer_q    <= timer_d;
            page_q     <= page_d;
            cap_page_q <= cap_page_d;
            cap_bin_q  <= cap_bin_d;
            valid_q    <= valid_d;
            acc_q      <= acc_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
        end
    end

    // Outputs: value only ever changes at COMMIT, so the mux never sees partial results.
    always_comb begin
        bus_io.value    = value_q;
        bus_io.page_sel = page_q;
        bus_io.busy     = (state_q != StIdle);
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomized self-checking bench for score_display_ctrl against a decimal/page-count model.
module tb_score_display_ctrl;

    localparam int unsigned IN_W = 14;
    localparam int unsigned PT   = 40;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    score_display_ctrl_if #(.IN_W(IN_W)) bus_a ();
    score_display_ctrl_if #(.IN_W(IN_W)) bus_b ();

    score_display_ctrl #(.PAGE_TICKS(PT), .IN_W(IN_W), .BLANK_LZ(1'b1)) u_dut_a (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_a)
    );

    score_display_ctrl #(.PAGE_TICKS(PT), .IN_W(IN_W), .BLANK_LZ(1'b0)) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_b)
    );

    int errors = 0;
    int checks = 0;
    int m_ticks = 0;     // page-timer cycles elapsed since reset with hold low
    int m_src[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_value(input int n, input bit blz);
        int          s;
        int          d[4];
        logic [15:0] r;
        bit          lead;
        s = (n > 9999) ? 9999 : n;
        for (int i = 0; i < 4; i++) begin
            d[i] = s % 10;
            s    = s / 10;
        end
        lead = blz;
        r    = '0;
        for (int i = 3; i >= 0; i--) begin
            if (lead && i > 0 && d[i] == 0) begin
                r[i*4 +: 4] = 4'hF;
            end else begin
                lead        = 1'b0;
                r[i*4 +: 4] = 4'(d[i]);
            end
        end
        return r;
    endfunction

    function automatic int model_page();
        return (m_ticks / PT) % 3;
    endfunction

    function automatic int rand_src();
        case ($urandom % 4)
            0:       return $urandom_range(9);
            1:       return $urandom_range(999);
            2:       return $urandom_range(9999);
            default: return $urandom_range(16383);
        endcase
    endfunction

    // Advance one clock, keeping the page-timer model in step, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        if (reset) m_ticks = 0;
        else if (!bus_a.hold) m_ticks++;
        #1;
    endtask

    task automatic set_src(input int s, input int l, input int v);
        m_src[0] = s;
        m_src[1] = l;
        m_src[2] = v;
        bus_a.score = IN_W'(s);
        bus_a.lines = IN_W'(l);
        bus_a.level = IN_W'(v);
        bus_b.score = IN_W'(s);
        bus_b.lines = IN_W'(l);
        bus_b.level = IN_W'(v);
    endtask

    task automatic set_hold(input bit h);
        bus_a.hold = h;
        bus_b.hold = h;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus_a.busy && n < 100) begin
            tick();
            n++;
        end
        check_eq("idle_reached", 32'(bus_a.busy), 32'd0);
    endtask

    task automatic check_display(input string tag);
        int p;
        p = model_page();
        check_eq({tag, "_page"}, 32'(bus_a.page_sel), 32'(p));
        check_eq({tag, "_val_blz"}, 32'(bus_a.value), 32'(model_value(m_src[p], 1'b1)));
        check_eq({tag, "_val_zero"}, 32'(bus_b.value), 32'(model_value(m_src[p], 1'b0)));
    endtask

    task automatic convert_and_check(input string tag);
        int n;
        tick();
        wait_idle(n);
        check_display(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  glitch;
        bit  seen_busy;
        int  settle;
        logic [15:0] prev_a, prev_b;

        // Reset state
        reset = 1'b1;
        set_hold(1'b1);
        set_src(1234, 0, 0);
        tick();
        check_eq("rst_value_a", 32'(bus_a.value), 32'hFFFF);
        check_eq("rst_value_b", 32'(bus_b.value), 32'hFFFF);
        check_eq("rst_page", 32'(bus_a.page_sel), 32'd0);
        check_eq("rst_busy", 32'(bus_a.busy), 32'd0);
        reset = 1'b0;

        // First conversion: busy for 16 cycles, value steady until commit
        tick();
        n      = 0;
        glitch = 1'b0;
        while (bus_a.busy && n < 100) begin
            if (bus_a.value != 16'hFFFF) glitch = 1'b1;
            tick();
            n++;
        end
        check_eq("latency", 32'(n), 32'd16);
        check_eq("no_glitch", 32'(glitch), 32'd0);
        check_display("first");

        // No reconversion when nothing changed
        seen_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_a.busy) seen_busy = 1'b1;
        end
        check_eq("steady_idle", 32'(seen_busy), 32'd0);

        // Leading-zero handling and saturation
        set_src(7, 0, 0);
        convert_and_check("seven");
        set_src(0, 0, 0);
        convert_and_check("zero");
        set_src(12000, 0, 0);
        convert_and_check("sat");
        set_src(9999, 0, 0);
        seen_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_a.busy) seen_busy = 1'b1;
        end
        check_eq("sat_no_reconv", 32'(seen_busy), 32'd0);

        // Source change mid-shift: old value commits first, then the new one
        set_src(1234, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) tick();
        set_src(4321, 0, 0);
        wait_idle(n);
        check_eq("midshift_old", 32'(bus_a.value), 32'(model_value(1234, 1'b1)));
        tick();
        wait_idle(n);
        check_eq("midshift_lat", 32'(n), 32'd16);
        check_display("midshift_new");

        // Reset pulse mid-shift
        set_src(55, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        check_eq("rst2_value_a", 32'(bus_a.value), 32'hFFFF);
        check_eq("rst2_value_b", 32'(bus_b.value), 32'hFFFF);
        check_eq("rst2_busy", 32'(bus_a.busy), 32'd0);
        check_eq("rst2_page", 32'(bus_a.page_sel), 32'd0);
        reset = 1'b0;
        convert_and_check("after_rst");

        // Random sources with the page frozen
        for (int i = 0; i < 20; i++) begin
            set_src(rand_src(), rand_src(), rand_src());
            convert_and_check("rand_hold");
        end

        // Free-running pages: track page_sel and every committed value
        for (int r = 0; r < 3; r++) begin
            wait_idle(n);
            set_src(rand_src(), rand_src(), rand_src());
            set_hold(1'b0);
            settle = 0;
            prev_a = bus_a.value;
            prev_b = bus_b.value;
            for (int c = 0; c < 3 * PT + 25; c++) begin
                tick();
                settle++;
                check_eq("run_page", 32'(bus_a.page_sel), 32'(model_page()));
                if (bus_a.value != prev_a)
                    check_eq("run_commit_a", 32'(bus_a.value),
                             32'(model_value(m_src[model_page()], 1'b1)));
                if (bus_b.value != prev_b)
                    check_eq("run_commit_b", 32'(bus_b.value),
                             32'(model_value(m_src[model_page()], 1'b0)));
                if ((m_ticks % PT) == PT - 1 && settle >= 36)
                    check_display("page_end");
                prev_a = bus_a.value;
                prev_b = bus_b.value;
            end
            set_hold(1'b1);
            wait_idle(n);
            tick();
            wait_idle(n);
            check_display("run_frozen");
        end

        // Random sources frozen on whatever page the run ended on
        for (int i = 0; i < 10; i++) begin
            set_src(rand_src(), rand_src(), rand_src());
            convert_and_check("rand_hold2");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
